control_sequencer: RTL

- Parametrised multi-cycle sequencing core for the LEGv8 datapath.
- Fetches an instruction with a memory-ready handshake and latches it into an internal IR.
- Classifies the IR and steps through a class-dependent number of execute states, then waits on memory for loads/stores.
- Emits state, step index, class, retire strobe and trap/halt status; the external control-word ROM indexes on {iclass, step}.
- Adds over the previous unit: variable step count, memory wait states with timeout, halt, sticky trap, retired-instruction counter.

---
 rtl/control_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Multi-cycle LEGv8 sequencing core: fetch with handshake, class-dependent
// execute steps, memory wait with timeout, halt, sticky trap, retire counter.
module control_sequencer #(
  parameter int MAX_EX = 4,
  parameter int STEP_W = 2,
  parameter int WAIT_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic              mem_ready,
  input  logic              halt_req,
  output logic              ir_load,
  output logic              pc_enable,
  output logic              mem_access,
  output logic [2:0]        state,
  output logic [STEP_W-1:0] step,
  output logic [2:0]        iclass,
  output logic              trap,
  output logic [1:0]        trap_cause,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  localparam logic [2:0] FETCH   = 3'd0;
  localparam logic [2:0] EXEC    = 3'd1;
  localparam logic [2:0] MEMWAIT = 3'd2;
  localparam logic [2:0] HALT    = 3'd3;
  localparam logic [2:0] TRAP    = 3'd4;

  localparam logic [2:0] C_DIMM   = 3'd0;
  localparam logic [2:0] C_BRANCH = 3'd1;
  localparam logic [2:0] C_MEM    = 3'd2;
  localparam logic [2:0] C_DREG   = 3'd3;
  localparam logic [2:0] C_UNDEF  = 3'd7;

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = '1;
  localparam int MOVK_STEPS = (MAX_EX < 2) ? MAX_EX : 2;

  logic [31:0]       ir;
  logic [WAIT_W-1:0] wait_cnt;
  logic [STEP_W-1:0] last_step;
  logic              is_movk;
  logic              ir_unused;

  assign ir_unused = ^{ir[31:30], ir[22:0]};

  always_comb begin
    iclass = C_UNDEF;
    if (ir[28:26] == 3'b100)
      iclass = C_DIMM;
    else if (ir[28:26] == 3'b101)
      iclass = C_BRANCH;
    else if (ir[27:25] == 3'b101)
      iclass = C_DREG;
    else if (ir[27] && !ir[25])
      iclass = C_MEM;
  end

  assign is_movk   = (iclass == C_DIMM) && (ir[25:23] == 3'b101) && ir[29];
  assign last_step = is_movk ? STEP_W'(MOVK_STEPS - 1) : '0;

  assign mem_access = (state == FETCH) || (state == MEMWAIT);
  assign ir_load    = (state == FETCH) && mem_ready && !halt_req;
  assign pc_enable  = ((state == EXEC) && (step == last_step) &&
                       (iclass != C_UNDEF) && (iclass != C_MEM)) ||
                      ((state == MEMWAIT) && mem_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= FETCH;
      ir          <= '0;
      step        <= '0;
      wait_cnt    <= '0;
      trap        <= 1'b0;
      trap_cause  <= 2'b00;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      halted <= 1'b0;
      case (state)
        FETCH: begin
          if (halt_req) begin
            state    <= HALT;
            halted   <= 1'b1;
            wait_cnt <= '0;
          end else if (mem_ready) begin
            ir       <= instr;
            state    <= EXEC;
            step     <= '0;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LIMIT) begin
            state      <= TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'b10;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        EXEC: begin
          if (iclass == C_UNDEF) begin
            state      <= TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'b01;
            step       <= '0;
          end else if (step != last_step) begin
            step <= step + 1'b1;
          end else begin
            step     <= '0;
            wait_cnt <= '0;
            if (iclass == C_MEM) begin
              state <= MEMWAIT;
            end else begin
              state       <= FETCH;
              instr_count <= instr_count + 1'b1;
            end
          end
        end
        MEMWAIT: begin
          if (mem_ready) begin
            state       <= FETCH;
            wait_cnt    <= '0;
            instr_count <= instr_count + 1'b1;
          end else if (wait_cnt == WAIT_LIMIT) begin
            state      <= TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'b10;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        HALT: begin
          if (halt_req) begin
            halted <= 1'b1;
          end else begin
            state    <= FETCH;
            wait_cnt <= '0;
          end
        end
        default: ;  // TRAP is sticky until reset
      endcase
    end
  end

endmodule
